trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_if.sv | 45 ++++
 rtl/trap_ctrl.sv | 174 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundle of the signals exchanged between the execute stage,
// the CSR register file and the trap sequencer.
//   slave  : seen by trap_ctrl (requests and CSR contents in; CSR write port,
//            busy and redirect out)
//   master : seen by the surrounding core / CSR file (the opposite directions)
interface trap_ctrl_if;
  logic        exc_req;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_req;
  logic        irq_ok;
  logic [31:0] irq_pc;
  logic        int_pending;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        ins_wreq;
  logic [3:0]  ins_windex;
  logic [31:0] ins_wdata;
  logic        csr_wreq;
  logic [3:0]  csr_windex;
  logic [31:0] csr_wdata;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  exc_req, exc_cause, exc_pc, exc_tval, mret_req,
    input  irq_ok, irq_pc, int_pending,
    input  csr_mstatus, csr_mtvec, csr_mepc,
    input  ins_wreq, ins_windex, ins_wdata,
    output csr_wreq, csr_windex, csr_wdata,
    output busy, redirect_valid, redirect_pc
  );

  modport master (
    output exc_req, exc_cause, exc_pc, exc_tval, mret_req,
    output irq_ok, irq_pc, int_pending,
    output csr_mstatus, csr_mtvec, csr_mepc,
    output ins_wreq, ins_windex, ins_wdata,
    input  csr_wreq, csr_windex, csr_wdata,
    input  busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Accepts an exception, an enabled external interrupt or an MRET while idle,
// then serialises MEPC/MCAUSE/MTVAL/MSTATUS writes onto the single CSR write
// port and finishes with a one-cycle PC redirect. While idle, CSR-instruction
// writes pass straight through to the write port.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   trap_ctrl_if.slave: execute-stage requests, current CSR contents,
//         CSR-instruction write in; CSR write port, busy, redirect out
module trap_ctrl (
  input  logic         clk,
  input  logic         rstn,
  trap_ctrl_if.slave   bus
);

  localparam logic [3:0]  IDX_MSTATUS = 4'd0;
  localparam logic [3:0]  IDX_MEPC    = 4'd1;
  localparam logic [3:0]  IDX_MCAUSE  = 4'd2;
  localparam logic [3:0]  IDX_MTVAL   = 4'd3;
  localparam logic [31:0] IRQ_CAUSE   = 32'h8000_000B;
  localparam logic [31:0] IRQ_VEC_OFS = 32'd44;

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR
  } state_t;

  state_t      state;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic [3:0]  cause_q;
  logic        is_int_q;
  logic        is_mret_q;
  logic        busy_q;
  logic        redir_vld_q;
  logic [31:0] redir_pc_q;
  logic        irq_take;
  logic [31:0] target;

  // Trap entry: stash MIE in MPIE, disable interrupts, MPP = M.
  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: restore MIE from MPIE, set MPIE, MPP stays M (only mode we have).
  function automatic logic [31:0] mret_status(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                              input logic        is_int);
    logic [31:0] base;
    base = tvec & 32'hFFFF_FFFC;
    if (tvec[1:0] == 2'b01 && is_int)
      return base + IRQ_VEC_OFS;
    return base;
  endfunction

  assign irq_take = bus.int_pending & bus.csr_mstatus[3] & bus.irq_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      epc_q       <= '0;
      tval_q      <= '0;
      cause_q     <= '0;
      is_int_q    <= 1'b0;
      is_mret_q   <= 1'b0;
      busy_q      <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.exc_req) begin
            epc_q     <= bus.exc_pc;
            cause_q   <= bus.exc_cause;
            tval_q    <= bus.exc_tval;
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= W_EPC;
          end else if (irq_take) begin
            epc_q     <= bus.irq_pc;
            cause_q   <= '0;
            tval_q    <= '0;
            is_int_q  <= 1'b1;
            is_mret_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= W_EPC;
          end else if (bus.mret_req) begin
            is_int_q  <= 1'b0;
            is_mret_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= W_STATUS;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_TVAL;
        W_TVAL:   state <= W_STATUS;
        W_STATUS: begin
          redir_vld_q <= 1'b1;
          state       <= REDIR;
        end
        REDIR: begin
          redir_pc_q  <= target;
          redir_vld_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Targets are computed from the CSR values present in REDIR so that the
  // MSTATUS write of the previous cycle (and any earlier ones) is visible.
  assign target = is_mret_q ? (bus.csr_mepc & 32'hFFFF_FFFC)
                            : trap_target(bus.csr_mtvec, is_int_q);

  // Write port: instruction passthrough in IDLE, sequencer data otherwise.
  // MSTATUS data is built from the live CSR value so a CSR-instruction write
  // made in the accept cycle is not lost.
  always_comb begin
    bus.csr_wreq   = bus.ins_wreq;
    bus.csr_windex = bus.ins_windex;
    bus.csr_wdata  = bus.ins_wdata;
    case (state)
      W_EPC: begin
        bus.csr_wreq   = 1'b1;
        bus.csr_windex = IDX_MEPC;
        bus.csr_wdata  = epc_q;
      end
      W_CAUSE: begin
        bus.csr_wreq   = 1'b1;
        bus.csr_windex = IDX_MCAUSE;
        bus.csr_wdata  = is_int_q ? IRQ_CAUSE : {28'd0, cause_q};
      end
      W_TVAL: begin
        bus.csr_wreq   = 1'b1;
        bus.csr_windex = IDX_MTVAL;
        bus.csr_wdata  = is_int_q ? 32'd0 : tval_q;
      end
      W_STATUS: begin
        bus.csr_wreq   = 1'b1;
        bus.csr_windex = IDX_MSTATUS;
        bus.csr_wdata  = is_mret_q ? mret_status(bus.csr_mstatus)
                                   : trap_status(bus.csr_mstatus);
      end
      REDIR: begin
        bus.csr_wreq   = 1'b0;
        bus.csr_windex = '0;
        bus.csr_wdata  = '0;
      end
      default: ;
    endcase
  end

  assign bus.busy           = busy_q;
  assign bus.redirect_valid = redir_vld_q;
  assign bus.redirect_pc    = (state == REDIR) ? target : redir_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model that also
// plays the role of the CSR register file.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.exc_req = 0; bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_tval = 0;
    bus.mret_req = 0; bus.irq_ok = 0; bus.irq_pc = 0; bus.int_pending = 0;
    bus.csr_mstatus = 0; bus.csr_mtvec = 0; bus.csr_mepc = 0;
    bus.ins_wreq = 0; bus.ins_windex = 0; bus.ins_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic        mret;
    logic        pend;
    logic        ok;
    logic [31:0] ipc;
    logic [31:0] ms;
    logic [31:0] tvec;
    logic [31:0] mepc;
    int          nwr;
    logic [3:0][3:0]  widx;
    logic [3:0][31:0] wdat;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] held_rpc;

  function automatic vec_t mk(string n, logic e, logic [3:0] c, logic [31:0] p, logic [31:0] tv,
                              logic m, logic pd, logic o, logic [31:0] ip, logic [31:0] ms,
                              logic [31:0] tvec, logic [31:0] mepc, int nwr,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3,
                              logic [31:0] rpc);
    vec_t v;
    v.name = n; v.exc = e; v.cause = c; v.pc = p; v.tval = tv; v.mret = m;
    v.pend = pd; v.ok = o; v.ipc = ip; v.ms = ms; v.tvec = tvec; v.mepc = mepc;
    v.nwr = nwr; v.rpc = rpc;
    if (nwr == 4) begin
      v.widx[0] = 4'd1; v.widx[1] = 4'd2; v.widx[2] = 4'd3; v.widx[3] = 4'd0;
    end else begin
      v.widx[0] = 4'd0; v.widx[1] = 4'd0; v.widx[2] = 4'd0; v.widx[3] = 4'd0;
    end
    v.wdat[0] = d0; v.wdat[1] = d1; v.wdat[2] = d2; v.wdat[3] = d3;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    bus.exc_req = v.exc; bus.exc_cause = v.cause; bus.exc_pc = v.pc; bus.exc_tval = v.tval;
    bus.mret_req = v.mret; bus.int_pending = v.pend; bus.irq_ok = v.ok; bus.irq_pc = v.ipc;
    bus.csr_mstatus = v.ms; bus.csr_mtvec = v.tvec; bus.csr_mepc = v.mepc;
    bus.ins_wreq = 0;
    @(negedge clk);
    chk({v.name, " busy@T"}, 32'(bus.busy), 32'd0);
    next_cycle();
    bus.exc_req = 0; bus.mret_req = 0; bus.int_pending = 0;
    for (int i = 0; i < v.nwr; i++) begin
      @(negedge clk);
      chk($sformatf("%s wreq[%0d]", v.name, i), 32'(bus.csr_wreq), 32'd1);
      chk($sformatf("%s widx[%0d]", v.name, i), 32'(bus.csr_windex), 32'(v.widx[i]));
      chk($sformatf("%s wdat[%0d]", v.name, i), bus.csr_wdata, v.wdat[i]);
      chk($sformatf("%s busy[%0d]", v.name, i), 32'(bus.busy), 32'd1);
      chk($sformatf("%s rv[%0d]", v.name, i), 32'(bus.redirect_valid), 32'd0);
      next_cycle();
    end
    if (v.nwr > 0) begin
      @(negedge clk);
      chk({v.name, " redir wreq"}, 32'(bus.csr_wreq), 32'd0);
      chk({v.name, " redir busy"}, 32'(bus.busy), 32'd1);
      chk({v.name, " redir valid"}, 32'(bus.redirect_valid), 32'd1);
      chk({v.name, " redir pc"}, bus.redirect_pc, v.rpc);
      held_rpc = v.rpc;
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({v.name, " after busy"}, 32'(bus.busy), 32'd0);
      chk({v.name, " after rv"}, 32'(bus.redirect_valid), 32'd0);
      chk({v.name, " after wreq"}, 32'(bus.csr_wreq), 32'd0);
      chk({v.name, " after rpc"}, bus.redirect_pc, held_rpc);
      next_cycle();
    end
  endtask

  // ---------------- reference model for random phase ----------------
  typedef struct {
    logic        wreq;
    logic [3:0]  idx;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] csr [16];
  logic [31:0] last_rpc;

  function automatic cyc_t wr(logic [3:0] idx, logic [31:0] d, logic [31:0] rpc);
    cyc_t c;
    c.wreq = 1; c.idx = idx; c.data = d; c.rv = 0; c.rpc = rpc;
    return c;
  endfunction

  function automatic cyc_t rd(logic [31:0] rpc);
    cyc_t c;
    c.wreq = 0; c.idx = 0; c.data = 0; c.rv = 1; c.rpc = rpc;
    return c;
  endfunction

  task automatic random_phase(input int ncyc);
    cyc_t e;
    logic take_exc, take_irq, take_mret;
    logic [31:0] ms, tgt;
    logic [3:0] idx_pool [6];
    idx_pool[0] = 0; idx_pool[1] = 1; idx_pool[2] = 2;
    idx_pool[3] = 3; idx_pool[4] = 5; idx_pool[5] = 4'(9);
    for (int c = 0; c < ncyc; c++) begin
      bus.exc_req     = ($urandom_range(0, 9) == 0);
      bus.exc_cause   = 4'($urandom);
      bus.exc_pc      = $urandom;
      bus.exc_tval    = $urandom;
      bus.mret_req    = ($urandom_range(0, 9) == 0);
      bus.int_pending = ($urandom_range(0, 3) == 0);
      bus.irq_ok      = $urandom_range(0, 1) == 1;
      bus.irq_pc      = $urandom;
      bus.ins_wreq    = ($urandom_range(0, 2) == 0);
      bus.ins_windex  = idx_pool[$urandom_range(0, 5)];
      bus.ins_wdata   = $urandom;
      bus.csr_mstatus = csr[0];
      bus.csr_mepc    = csr[1];
      bus.csr_mtvec   = csr[5];
      @(negedge clk);
      if (q.size() == 0) begin
        e.wreq = bus.ins_wreq; e.idx = bus.ins_windex; e.data = bus.ins_wdata;
        e.rv = 0; e.rpc = last_rpc;
        chk("rnd idle busy", 32'(bus.busy), 32'd0);
      end else begin
        e = q[0];
        chk("rnd seq busy", 32'(bus.busy), 32'd1);
      end
      chk("rnd wreq", 32'(bus.csr_wreq), 32'(e.wreq));
      if (e.wreq || q.size() == 0) begin
        chk("rnd widx", 32'(bus.csr_windex), 32'(e.idx));
        chk("rnd wdata", bus.csr_wdata, e.data);
      end
      chk("rnd rv", 32'(bus.redirect_valid), 32'(e.rv));
      chk("rnd rpc", bus.redirect_pc, e.rpc);
      // advance the model
      if (q.size() == 0) begin
        take_exc  = bus.exc_req;
        take_irq  = !take_exc && bus.int_pending && csr[0][3] && bus.irq_ok;
        take_mret = !take_exc && !take_irq && bus.mret_req;
        if (bus.ins_wreq) csr[bus.ins_windex] = bus.ins_wdata;
        ms = csr[0];
        if (take_exc || take_irq) begin
          tgt = {csr[5][31:2], 2'b00};
          if (take_irq && csr[5][1:0] == 2'b01) tgt = tgt + 32'd44;
          q.push_back(wr(4'd1, take_exc ? bus.exc_pc : bus.irq_pc, last_rpc));
          q.push_back(wr(4'd2, take_exc ? {28'd0, bus.exc_cause} : 32'h8000_000B, last_rpc));
          q.push_back(wr(4'd3, take_exc ? bus.exc_tval : 32'd0, last_rpc));
          q.push_back(wr(4'd0, (ms & ~32'h1888) | 32'h1800 | (ms[3] ? 32'h80 : 32'h0), last_rpc));
          q.push_back(rd(tgt));
        end else if (take_mret) begin
          q.push_back(wr(4'd0, (ms & ~32'h1888) | 32'h1880 | (ms[7] ? 32'h8 : 32'h0), last_rpc));
          q.push_back(rd({csr[1][31:2], 2'b00}));
        end
      end else begin
        e = q.pop_front();
        if (e.wreq) csr[e.idx] = e.data;
        if (e.rv) last_rpc = e.rpc;
      end
      next_cycle();
    end
  endtask

  initial begin
    clear_inputs();
    held_rpc = 0;
    bus.ins_wreq = 1; bus.ins_windex = 4'd6; bus.ins_wdata = 32'h1357_9BDF;
    #2;
    // reset state
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset rv", 32'(bus.redirect_valid), 32'd0);
    chk("reset rpc", bus.redirect_pc, 32'd0);
    chk("reset pass wreq", 32'(bus.csr_wreq), 32'd1);
    chk("reset pass widx", 32'(bus.csr_windex), 32'd6);
    chk("reset pass wdata", bus.csr_wdata, 32'h1357_9BDF);
    next_cycle(); next_cycle();
    bus.ins_wreq = 0;
    rstn = 1;
    next_cycle();

    vecs.push_back(mk("exc", 1, 4'd2, 32'h40, 32'hDEAD, 0, 0, 0, 0, 32'h8, 32'h100, 0,
                      4, 32'h40, 32'h2, 32'hDEAD, 32'h1880, 32'h100));
    vecs.push_back(mk("virq", 0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h8, 32'h201, 0,
                      4, 32'h80, 32'h8000_000B, 32'h0, 32'h1880, 32'h22C));
    vecs.push_back(mk("irq_mie0", 0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h0, 32'h201, 0,
                      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mret", 0, 0, 0, 0, 1, 0, 0, 0, 32'h1880, 32'h100, 32'h44,
                      1, 32'h1888, 0, 0, 0, 32'h44));
    vecs.push_back(mk("exc_mret", 1, 4'd5, 32'h1000, 32'h7, 1, 0, 0, 0, 32'h0, 32'h104, 32'h88,
                      4, 32'h1000, 32'h5, 32'h7, 32'h1800, 32'h104));
    vecs.push_back(mk("exc_irq", 1, 4'd3, 32'h200, 32'h55, 0, 1, 1, 32'h999, 32'h8, 32'h301, 0,
                      4, 32'h200, 32'h3, 32'h55, 32'h1880, 32'h300));
    vecs.push_back(mk("irq_notok", 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h8, 32'h201, 0,
                      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("irq_direct", 0, 0, 0, 0, 0, 1, 1, 32'h84, 32'hA, 32'h400, 0,
                      4, 32'h84, 32'h8000_000B, 32'h0, 32'h1882, 32'h400));
    vecs.push_back(mk("mret_mpie0", 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h100, 32'h47,
                      1, 32'h1880, 0, 0, 0, 32'h44));
    foreach (vecs[i]) run_vec(vecs[i]);

    // ins write forwarded at accept, dropped during W_EPC / W_CAUSE
    bus.exc_req = 1; bus.exc_cause = 4'd4; bus.exc_pc = 32'h500; bus.exc_tval = 32'h9;
    bus.csr_mstatus = 32'h8; bus.csr_mtvec = 32'h100;
    bus.ins_wreq = 1; bus.ins_windex = 4'd6; bus.ins_wdata = 32'h1234;
    @(negedge clk);
    chk("ins@T wreq", 32'(bus.csr_wreq), 32'd1);
    chk("ins@T widx", 32'(bus.csr_windex), 32'd6);
    chk("ins@T wdata", bus.csr_wdata, 32'h1234);
    next_cycle();
    bus.exc_req = 0; bus.ins_windex = 4'd7; bus.ins_wdata = 32'h5678;
    @(negedge clk);
    chk("ins@EPC widx", 32'(bus.csr_windex), 32'd1);
    chk("ins@EPC wdata", bus.csr_wdata, 32'h500);
    next_cycle();
    @(negedge clk);
    chk("ins@CAUSE widx", 32'(bus.csr_windex), 32'd2);
    chk("ins@CAUSE wdata", bus.csr_wdata, 32'h4);
    next_cycle();
    // reset asserted during W_TVAL
    @(negedge clk);
    chk("pre-rst widx", 32'(bus.csr_windex), 32'd3);
    #2 rstn = 0;
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst rv", 32'(bus.redirect_valid), 32'd0);
    chk("rst rpc", bus.redirect_pc, 32'd0);
    chk("rst pass widx", 32'(bus.csr_windex), 32'd7);
    chk("rst pass wdata", bus.csr_wdata, 32'h5678);
    next_cycle();
    rstn = 1;
    bus.ins_wreq = 0;
    held_rpc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post-rst busy", 32'(bus.busy), 32'd0);
      chk("post-rst rv", 32'(bus.redirect_valid), 32'd0);
      chk("post-rst rpc", bus.redirect_pc, 32'd0);
      next_cycle();
    end
    run_vec(vecs[0]);

    // randomized run from a fresh reset
    rstn = 0;
    next_cycle();
    rstn = 1;
    for (int i = 0; i < 16; i++) csr[i] = $urandom;
    last_rpc = 0;
    random_phase(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
